// File: rtl/mult_div_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: R-type funct
// codes, FSM state encoding and the operation kind carried through CALC/ADJ.
package mult_div_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_ADJ  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MUL_S = 2'b00,
    MUL_U = 2'b01,
    DIV_S = 2'b10,
    DIV_U = 2'b11
  } op_kind_e;

  function automatic logic op_is_div(input op_kind_e k);
    return (k == DIV_S) || (k == DIV_U);
  endfunction

  function automatic logic op_is_signed(input op_kind_e k);
    return (k == MUL_S) || (k == DIV_S);
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the multiply/divide datapath. The accumulator holds
// {partial product, multiplier} for multiplies and {remainder, dividend/
// quotient} for divides, so both shift the same 2*DATA_W register.
module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_kind_e              i_op,
  input  logic [2*DATA_W-1:0]   i_acc,
  input  logic [DATA_W-1:0]     i_b,
  output logic [2*DATA_W-1:0]   o_acc
);

  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] trial;
  logic              borrow;

  // Shift-add for multiply, restoring trial-subtract for divide.
  always_comb begin
    addend  = i_acc[0] ? i_b : '0;
    add_sum = {1'b0, i_acc[2*DATA_W-1:DATA_W]} + {1'b0, addend};
    // Remainder shifted left with the next dividend bit: DATA_W+1 wide so
    // the comparison against the divisor sees the carried-out bit.
    shifted = i_acc[2*DATA_W-1:DATA_W-1];
    borrow  = shifted < {1'b0, i_b};
    // When no borrow the true difference is below the divisor, so the low
    // DATA_W bits of the modular subtract are exact.
    trial   = shifted[DATA_W-1:0] - i_b;
    if (op_is_div(i_op)) begin
      if (borrow) o_acc = {shifted[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b0};
      else        o_acc = {trial, i_acc[DATA_W-2:0], 1'b1};
    end else begin
      o_acc = {add_sum, i_acc[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/control_mult_div.sv
// HI/LO owner for the MIPS core: sequences 32-iteration MULT/MULTU/DIV/DIVU,
// performs single-cycle MTHI/MTLO, and stalls MFHI/MFLO while busy.
module control_mult_div
  import mult_div_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BITS_FUNCT = 6,
  parameter int CNT_W      = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [BITS_FUNCT-1:0] i_funct,
  input  logic [DATA_W-1:0]     i_rs,
  input  logic [DATA_W-1:0]     i_rt,
  input  logic                  i_cancel,
  input  logic                  i_mf_req,
  output logic [DATA_W-1:0]     o_hi,
  output logic [DATA_W-1:0]     o_lo,
  output logic                  o_busy,
  output logic                  o_stall,
  output logic                  o_done,
  output logic                  o_div_zero
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   rs_raw_q, rs_raw_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  op_kind_e            op_q, op_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic                dz_q, dz_d;
  logic                done_q, done_d;
  logic                div_zero_q, div_zero_d;

  // Start decode
  logic                is_muldiv, is_mthi, is_mtlo;
  op_kind_e            op_n;
  logic                sa_n, sb_n;
  logic [DATA_W-1:0]   a_mag, b_mag;

  // ADJ fix-up
  logic                neg;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   q_raw, r_raw;
  logic [DATA_W-1:0]   res_hi, res_lo;

  logic [2*DATA_W-1:0] step_acc;

  mult_div_step #(.DATA_W(DATA_W)) u_step (
    .i_op  (op_q),
    .i_acc (acc_q),
    .i_b   (b_q),
    .o_acc (step_acc)
  );

  // Decode the requested funct into an op kind and operand magnitudes.
  always_comb begin
    is_muldiv = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    op_n      = MUL_S;
    unique case (i_funct)
      FN_MULT:  begin is_muldiv = 1'b1; op_n = MUL_S; end
      FN_MULTU: begin is_muldiv = 1'b1; op_n = MUL_U; end
      FN_DIV:   begin is_muldiv = 1'b1; op_n = DIV_S; end
      FN_DIVU:  begin is_muldiv = 1'b1; op_n = DIV_U; end
      FN_MTHI:  is_mthi = 1'b1;
      FN_MTLO:  is_mtlo = 1'b1;
      default:  ;
    endcase
    sa_n  = op_is_signed(op_n) & i_rs[DATA_W-1];
    sb_n  = op_is_signed(op_n) & i_rt[DATA_W-1];
    a_mag = sa_n ? (~i_rs + 1'b1) : i_rs;
    b_mag = sb_n ? (~i_rt + 1'b1) : i_rt;
  end

  // Sign correction and divide-by-zero override of the finished accumulator.
  always_comb begin
    neg   = sa_q ^ sb_q;
    prod  = neg ? (~acc_q + 1'b1) : acc_q;
    q_raw = acc_q[DATA_W-1:0];
    r_raw = acc_q[2*DATA_W-1:DATA_W];
    if (op_is_div(op_q)) begin
      if (dz_q) begin
        res_lo = '1;
        res_hi = rs_raw_q;
      end else begin
        res_lo = neg  ? (~q_raw + 1'b1) : q_raw;
        res_hi = sa_q ? (~r_raw + 1'b1) : r_raw;
      end
    end else begin
      res_hi = prod[2*DATA_W-1:DATA_W];
      res_lo = prod[DATA_W-1:0];
    end
  end

  // Next-state logic for the IDLE/CALC/ADJ sequencer and HI/LO.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    b_d        = b_q;
    rs_raw_d   = rs_raw_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    op_d       = op_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A flush in the same cycle as a request suppresses it entirely.
        if (i_start && !i_cancel) begin
          if (is_muldiv) begin
            // Multiplier and dividend both start in the low half.
            acc_d    = {{DATA_W{1'b0}}, a_mag};
            b_d      = b_mag;
            rs_raw_d = i_rs;
            op_d     = op_n;
            sa_d     = sa_n;
            sb_d     = sb_n;
            dz_d     = op_is_div(op_n) && (i_rt == '0);
            cnt_d    = CNT_W'(DATA_W - 1);
            state_d  = ST_CALC;
          end else if (is_mthi) begin
            hi_d = i_rs;
          end else if (is_mtlo) begin
            lo_d = i_rs;
          end
        end
      end
      ST_CALC: begin
        if (i_cancel) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          if (cnt_q == '0) state_d = ST_ADJ;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_ADJ: begin
        state_d = ST_IDLE;
        if (!i_cancel) begin
          hi_d       = res_hi;
          lo_d       = res_lo;
          done_d     = 1'b1;
          div_zero_d = dz_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and HI/LO registers; everything clears on reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      rs_raw_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      op_q       <= MUL_S;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      rs_raw_q   <= rs_raw_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      op_q       <= op_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign o_hi       = hi_q;
  assign o_lo       = lo_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_stall    = o_busy & i_mf_req;
  assign o_done     = done_q;
  assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_control_mult_div.sv
// Bench for control_mult_div: directed scenarios plus randomized ops against
// an arithmetic reference model of HI/LO.
module tb_control_mult_div;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_start = 1'b0;
  logic [5:0]  i_funct = '0;
  logic [31:0] i_rs = '0;
  logic [31:0] i_rt = '0;
  logic        i_cancel = 1'b0;
  logic        i_mf_req = 1'b0;
  logic [31:0] o_hi, o_lo;
  logic        o_busy, o_stall, o_done, o_div_zero;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 i_clk = ~i_clk;

  control_mult_div dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_funct(i_funct),
    .i_rs(i_rs), .i_rt(i_rt), .i_cancel(i_cancel), .i_mf_req(i_mf_req),
    .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_stall(o_stall),
    .o_done(o_done), .o_div_zero(o_div_zero)
  );

  // Architectural result of one instruction on the HI/LO pair.
  function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo, output bit dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    dz = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      F_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      F_DIV: begin
        if (b == 0) begin lo = '1; hi = a; dz = 1; end
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      F_DIVU: begin
        if (b == 0) begin lo = '1; hi = a; dz = 1; end
        else begin lo = a / b; hi = a % b; end
      end
      F_MTHI: hi = a;
      F_MTLO: lo = a;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Present a request for exactly one rising edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge i_clk);
    i_start = 1'b1; i_funct = f; i_rs = a; i_rt = b;
    @(negedge i_clk);
    i_start = 1'b0; i_funct = '0;
  endtask

  // Follow an operation until busy drops; records what was seen on the way.
  task automatic wait_done(output int busy_n, output int stall_n, output bit early_done,
                           output bit done_v, output bit dz_v, output bit stall_after,
                           output bit done_next);
    busy_n = 0; stall_n = 0; early_done = 0;
    while (o_busy === 1'b1 && busy_n < 200) begin
      busy_n++;
      if (o_stall === 1'b1) stall_n++;
      if (o_done === 1'b1) early_done = 1;
      @(negedge i_clk);
    end
    if (busy_n >= 200) begin
      errors++;
      $display("FAIL wait_done timeout busy_cycles=%0d limit=200", busy_n);
    end
    done_v = o_done; dz_v = o_div_zero; stall_after = o_stall;
    @(negedge i_clk);
    done_next = o_done;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_mf_req = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", o_hi); end
    checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", o_lo); end
    checks++; if ({o_busy, o_done, o_div_zero, o_stall} !== 4'b0)
      begin errors++; $display("FAIL reset_flags got=%b exp=0000", {o_busy, o_done, o_div_zero, o_stall}); end
    i_reset_n = 1'b1; i_mf_req = 1'b0;
    @(negedge i_clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b exp=0", o_busy); end
    m_hi = '0; m_lo = '0;
  endtask

  // Directed mult/div cases with literal expected results.
  task automatic test_directed();
    logic [5:0]  f [5]  = '{F_MULT, F_MULTU, F_DIV, F_DIV, F_DIVU};
    logic [31:0] a [5]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
    logic [31:0] b [5]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] eh [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h64};
    logic [31:0] el [5] = '{32'hFFFF_FFEB, 32'h1, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    bit ez [5] = '{0, 0, 0, 0, 1};
    int bn, sn; bit ed, dv, zv, sa, dn;
    for (int i = 0; i < 5; i++) begin
      issue(f[i], a[i], b[i]);
      wait_done(bn, sn, ed, dv, zv, sa, dn);
      checks++; if (bn !== 33) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, bn); end
      checks++; if (o_hi !== eh[i]) begin errors++; $display("FAIL dir%0d_hi got=%h exp=%h", i, o_hi, eh[i]); end
      checks++; if (o_lo !== el[i]) begin errors++; $display("FAIL dir%0d_lo got=%h exp=%h", i, o_lo, el[i]); end
      checks++; if ({ed, dv, dn} !== 3'b010) begin errors++; $display("FAIL dir%0d_done early/at/after got=%b exp=010", i, {ed, dv, dn}); end
      checks++; if (zv !== ez[i]) begin errors++; $display("FAIL dir%0d_div_zero got=%b exp=%b", i, zv, ez[i]); end
      m_hi = eh[i]; m_lo = el[i];
    end
  endtask

  task automatic test_mt();
    @(negedge i_clk);
    i_start = 1'b1; i_funct = F_MTHI; i_rs = 32'h1234_5678;
    @(negedge i_clk);
    checks++; if (o_hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi got=%h exp=12345678", o_hi); end
    checks++; if (o_lo !== m_lo) begin errors++; $display("FAIL mthi_lo_kept got=%h exp=%h", o_lo, m_lo); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", o_busy); end
    i_funct = F_MTLO; i_rs = 32'h9ABC_DEF0;
    @(negedge i_clk);
    i_start = 1'b0; i_funct = '0;
    checks++; if (o_lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo got=%h exp=9abcdef0", o_lo); end
    checks++; if ({o_busy, o_done} !== 2'b00) begin errors++; $display("FAIL mtlo_busy_done got=%b exp=00", {o_busy, o_done}); end
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
  endtask

  task automatic test_stall();
    int bn, sn; bit ed, dv, zv, sa, dn;
    i_mf_req = 1'b1;
    issue(F_MULT, 32'd5, 32'd6);
    wait_done(bn, sn, ed, dv, zv, sa, dn);
    checks++; if (sn !== 33) begin errors++; $display("FAIL stall_cycles got=%0d exp=33", sn); end
    checks++; if (sa !== 1'b0) begin errors++; $display("FAIL stall_after got=%b exp=0", sa); end
    checks++; if ({o_hi, o_lo} !== {32'd0, 32'd30}) begin errors++; $display("FAIL stall_result got=%h_%h exp=0_1e", o_hi, o_lo); end
    i_mf_req = 1'b0;
    m_hi = 32'd0; m_lo = 32'd30;
  endtask

  task automatic test_cancel();
    int dcount = 0;
    issue(F_MULT, 32'h1234, 32'h5678);
    repeat (9) @(negedge i_clk);
    i_cancel = 1'b1;
    @(negedge i_clk);
    i_cancel = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got=%b exp=0", o_busy); end
    for (int i = 0; i < 40; i++) begin
      if (o_done === 1'b1) dcount++;
      @(negedge i_clk);
    end
    checks++; if (dcount !== 0) begin errors++; $display("FAIL cancel_done_pulses got=%0d exp=0", dcount); end
    checks++; if ({o_hi, o_lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL cancel_hilo got=%h_%h exp=%h_%h", o_hi, o_lo, m_hi, m_lo); end
    // start and cancel together in IDLE: nothing happens
    @(negedge i_clk);
    i_start = 1'b1; i_cancel = 1'b1; i_funct = F_MTHI; i_rs = 32'hDEAD_BEEF;
    @(negedge i_clk);
    i_funct = F_DIVU;
    @(negedge i_clk);
    i_start = 1'b0; i_cancel = 1'b0; i_funct = '0;
    checks++; if (o_hi !== m_hi) begin errors++; $display("FAIL cancel_idle_hi got=%h exp=%h", o_hi, m_hi); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL cancel_idle_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_busy_ignore();
    int bn, sn; bit ed, dv, zv, sa, dn;
    issue(F_MULTU, 32'd3, 32'd4);
    i_start = 1'b1; i_funct = F_MTHI; i_rs = 32'hFFFF;
    @(negedge i_clk);
    i_funct = F_DIV; i_rs = 32'd9; i_rt = 32'd3;
    @(negedge i_clk);
    i_start = 1'b0; i_funct = '0;
    wait_done(bn, sn, ed, dv, zv, sa, dn);
    checks++; if (bn !== 31) begin errors++; $display("FAIL busy_ignore_cycles got=%0d exp=31", bn); end
    checks++; if ({o_hi, o_lo} !== {32'd0, 32'd12}) begin errors++; $display("FAIL busy_ignore_result got=%h_%h exp=0_c", o_hi, o_lo); end
    m_hi = 32'd0; m_lo = 32'd12;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int bn, sn; bit ed, dv, zv, sa, dn;
    issue(F_DIVU, 32'd1000, 32'd7);
    while (o_busy === 1'b1 && n < 100) begin n++; @(negedge i_clk); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", o_done); end
    i_start = 1'b1; i_funct = F_MULTU; i_rs = 32'h0001_0000; i_rt = 32'h0003_0000;
    @(negedge i_clk);
    i_start = 1'b0; i_funct = '0;
    checks++; if ({o_hi, o_lo} !== {32'd6, 32'd142}) begin errors++; $display("FAIL b2b_first got=%h_%h exp=6_8e", o_hi, o_lo); end
    wait_done(bn, sn, ed, dv, zv, sa, dn);
    checks++; if (bn !== 33) begin errors++; $display("FAIL b2b_second_cycles got=%0d exp=33", bn); end
    checks++; if ({o_hi, o_lo} !== {32'd3, 32'd0}) begin errors++; $display("FAIL b2b_second got=%h_%h exp=3_0", o_hi, o_lo); end
    m_hi = 32'd3; m_lo = 32'd0;
  endtask

  task automatic test_reset_mid();
    issue(F_MTHI, 32'hA5A5_A5A5, 32'd0);
    issue(F_MULT, 32'hFFFF, 32'hFFFF);
    repeat (14) @(negedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    checks++; if ({o_hi, o_lo} !== 64'd0) begin errors++; $display("FAIL reset_mid_hilo got=%h_%h exp=0_0", o_hi, o_lo); end
    checks++; if ({o_busy, o_done, o_div_zero} !== 3'b000) begin errors++; $display("FAIL reset_mid_flags got=%b exp=000", {o_busy, o_done, o_div_zero}); end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++; if ({o_busy, o_done} !== 2'b00) begin errors++; $display("FAIL reset_mid_after got=%b exp=00", {o_busy, o_done}); end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_random();
    logic [5:0] fs [6] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
    logic [5:0] f; logic [31:0] a, b; bit edz;
    int bn, sn; bit ed, dv, zv, sa, dn;
    for (int i = 0; i < 30; i++) begin
      f = fs[$urandom_range(0, 5)];
      a = pick_val();
      b = pick_val();
      ref_op(f, a, b, m_hi, m_lo, edz);
      issue(f, a, b);
      if (f == F_MTHI || f == F_MTLO) begin
        checks++; if ({o_hi, o_lo, o_busy} !== {m_hi, m_lo, 1'b0})
          begin errors++; $display("FAIL rnd%0d_mt f=%b got=%h_%h busy=%b exp=%h_%h", i, f, o_hi, o_lo, o_busy, m_hi, m_lo); end
      end else begin
        wait_done(bn, sn, ed, dv, zv, sa, dn);
        checks++; if ({o_hi, o_lo} !== {m_hi, m_lo})
          begin errors++; $display("FAIL rnd%0d_result f=%b a=%h b=%h got=%h_%h exp=%h_%h", i, f, a, b, o_hi, o_lo, m_hi, m_lo); end
        checks++; if ({bn == 33, dv, zv} !== {1'b1, 1'b1, edz})
          begin errors++; $display("FAIL rnd%0d_ctrl busy=%0d done=%b dz=%b exp 33/1/%b", i, bn, dv, zv, edz); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt();
    test_stall();
    test_cancel();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
